// File: rtl/clk_divider_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Config fields are carried at a fixed width and zero-extended from CNT_W.
package clk_divider_pkg;

    localparam int unsigned CFG_W = 32;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    typedef struct packed {
        logic [CFG_W-1:0] high;
        logic [CFG_W-1:0] low;
    } clkdiv_cfg_t;

    function automatic logic [CFG_W-1:0] clamp_len(input logic [CFG_W-1:0] x);
        return (x == '0) ? CFG_W'(1) : x;
    endfunction

endpackage

// File: rtl/clk_divider_cfg_shadow.sv
// Config handshake: captures a clamped (H, L) pair into a shadow register and
// promotes it to the active config at the next period boundary.
module clk_divider_cfg_shadow
    import clk_divider_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RESET_HIGH = 512,
    parameter int unsigned RESET_LOW  = 512
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid_i,
    input  logic [CNT_W-1:0] cfg_high_i,
    input  logic [CNT_W-1:0] cfg_low_i,
    input  logic             boundary_i,
    output logic             cfg_ready_o,
    output logic [CFG_W-1:0] cur_high_o,
    output logic [CFG_W-1:0] cur_low_o,
    output logic [CFG_W-1:0] nxt_high_o,
    output logic [CFG_W-1:0] nxt_low_o
);

    clkdiv_cfg_t shadow_q, shadow_d;
    clkdiv_cfg_t active_q, active_d;
    logic        pending_q, pending_d;
    logic        take;

    assign take = cfg_valid_i & ~pending_q;

    // Apply needs pending_q and capture needs !pending_q, so a capture on a
    // boundary edge naturally waits for the following boundary.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (boundary_i && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (take) begin
            shadow_d.high = clamp_len(CFG_W'(cfg_high_i));
            shadow_d.low  = clamp_len(CFG_W'(cfg_low_i));
            pending_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q      <= '0;
            active_q.high <= CFG_W'(RESET_HIGH);
            active_q.low  <= CFG_W'(RESET_LOW);
            pending_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign cfg_ready_o = ~pending_q;
    assign cur_high_o  = active_q.high;
    assign cur_low_o   = active_q.low;
    assign nxt_high_o  = active_d.high;
    assign nxt_low_o   = active_d.low;

endmodule

// File: rtl/clk_divider_prog.sv
// Programmable-duty clock-enable divider with edge and mid-phase pulses.
// Phase FSM and counter here; config handshake lives in clk_divider_cfg_shadow.
module clk_divider_prog
    import clk_divider_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RESET_HIGH = 512,
    parameter int unsigned RESET_LOW  = 512
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable_clk,
    input  logic             sync_restart,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    output logic             new_clk,
    output logic             rising_edge,
    output logic             falling_edge,
    output logic             middle_of_high_level,
    output logic             middle_of_low_level
);

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             new_clk_q, new_clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             midh_q, midh_d;
    logic             midl_q, midl_d;
    logic             boundary;
    logic             last;
    logic [CFG_W-1:0] cur_high, cur_low, nxt_high, nxt_low, cur_len;

    clk_divider_cfg_shadow #(
        .CNT_W      (CNT_W),
        .RESET_HIGH (RESET_HIGH),
        .RESET_LOW  (RESET_LOW)
    ) u_shadow (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_valid_i (cfg_valid),
        .cfg_high_i  (cfg_high),
        .cfg_low_i   (cfg_low),
        .boundary_i  (boundary),
        .cfg_ready_o (cfg_ready),
        .cur_high_o  (cur_high),
        .cur_low_o   (cur_low),
        .nxt_high_o  (nxt_high),
        .nxt_low_o   (nxt_low)
    );

    assign cur_len = (phase_q == PH_HIGH) ? cur_high : cur_low;
    assign last    = (CFG_W'(cnt_q) == (cur_len - CFG_W'(1)));

    // Pulses are decoded from the next state so every output is a plain flop.
    // The mid-low compare uses the next active config, which matters when a
    // new config with L=1 takes effect on the boundary edge itself.
    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        new_clk_d = new_clk_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        midh_d    = 1'b0;
        midl_d    = 1'b0;
        boundary  = 1'b0;
        if (sync_restart) begin
            phase_d   = PH_LOW;
            cnt_d     = '0;
            new_clk_d = 1'b0;
            fall_d    = new_clk_q;
            boundary  = 1'b1;
        end else if (enable_clk) begin
            if (last) begin
                phase_d  = (phase_q == PH_HIGH) ? PH_LOW : PH_HIGH;
                cnt_d    = '0;
                boundary = (phase_q == PH_HIGH);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            new_clk_d = (phase_d == PH_HIGH);
            rise_d    = (phase_d == PH_HIGH) && last;
            fall_d    = (phase_d == PH_LOW) && last;
            midh_d    = (phase_d == PH_HIGH) && (CFG_W'(cnt_d) == (nxt_high >> 1));
            midl_d    = (phase_d == PH_LOW) && (CFG_W'(cnt_d) == (nxt_low >> 1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= PH_LOW;
            cnt_q     <= '0;
            new_clk_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            midh_q    <= 1'b0;
            midl_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            new_clk_q <= new_clk_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            midh_q    <= midh_d;
            midl_q    <= midl_d;
        end
    end

    assign new_clk              = new_clk_q;
    assign rising_edge          = rise_q;
    assign falling_edge         = fall_q;
    assign middle_of_high_level = midh_q;
    assign middle_of_low_level  = midl_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog; a period-position model predicts each
// cycle's outputs into a scoreboard queue that is drained after every edge.
module tb_clk_divider_prog;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned RH    = 3;
    localparam int unsigned RL    = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             enable_clk = 1'b0;
    logic             sync_restart = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_high = '0;
    logic [CNT_W-1:0] cfg_low = '0;
    logic             new_clk, rising_edge, falling_edge;
    logic             middle_of_high_level, middle_of_low_level;

    typedef struct packed {
        logic nc;
        logic re;
        logic fe;
        logic mh;
        logic ml;
        logic rdy;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Model state: position within the current period, active/shadow config.
    int   m_k, m_h, m_l, m_sh, m_sl;
    bit   m_pend;
    logic m_nc;

    clk_divider_prog #(
        .CNT_W      (CNT_W),
        .RESET_HIGH (RH),
        .RESET_LOW  (RL)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .enable_clk           (enable_clk),
        .sync_restart         (sync_restart),
        .cfg_valid            (cfg_valid),
        .cfg_ready            (cfg_ready),
        .cfg_high             (cfg_high),
        .cfg_low              (cfg_low),
        .new_clk              (new_clk),
        .rising_edge          (rising_edge),
        .falling_edge         (falling_edge),
        .middle_of_high_level (middle_of_high_level),
        .middle_of_low_level  (middle_of_low_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s t=%0t observed=%0b expected=%0b", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_k    = 0;
        m_h    = RH;
        m_l    = RL;
        m_sh   = 0;
        m_sl   = 0;
        m_pend = 1'b0;
        m_nc   = 1'b0;
    endtask

    task automatic check_out();
        exp_t e;
        compared++;
        assert (sb_q.size() != 0) else begin
            mismatched++;
            $error("FAIL sb_empty observed=0 expected=1");
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("new_clk", new_clk, e.nc);
            chk("rising_edge", rising_edge, e.re);
            chk("falling_edge", falling_edge, e.fe);
            chk("mid_high", middle_of_high_level, e.mh);
            chk("mid_low", middle_of_low_level, e.ml);
            chk("cfg_ready", cfg_ready, e.rdy);
        end
    endtask

    // Called just after a rising edge; drives one cycle and checks the result.
    task automatic step(input logic en, input logic rs, input logic v, input int h, input int l);
        exp_t e;
        bit   take;
        enable_clk   = en;
        sync_restart = rs;
        cfg_valid    = v;
        cfg_high     = CNT_W'(h);
        cfg_low      = CNT_W'(l);
        take = v && !m_pend;
        e = '0;
        if (rs) begin
            if (m_pend) begin
                m_h = m_sh;
                m_l = m_sl;
                m_pend = 1'b0;
            end
            e.fe = m_nc;
            m_k  = 0;
            m_nc = 1'b0;
        end else if (en) begin
            m_k++;
            if (m_k == m_h + m_l) begin
                m_k = 0;
                if (m_pend) begin
                    m_h = m_sh;
                    m_l = m_sl;
                    m_pend = 1'b0;
                end
            end
            m_nc = (m_k >= m_l) && (m_k < m_l + m_h);
            e.re = (m_k == m_l);
            e.fe = (m_k == 0);
            e.ml = (m_k == m_l / 2);
            e.mh = (m_k == m_l + m_h / 2);
        end
        e.nc = m_nc;
        if (take) begin
            m_sh = (h == 0) ? 1 : h;
            m_sl = (l == 0) ? 1 : l;
            m_pend = 1'b1;
        end
        e.rdy = !m_pend;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    // Asserts reset between edges and checks the asynchronous clear.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_new_clk", new_clk, 1'b0);
        chk("rst_rising", rising_edge, 1'b0);
        chk("rst_falling", falling_edge, 1'b0);
        chk("rst_mid_high", middle_of_high_level, 1'b0);
        chk("rst_mid_low", middle_of_low_level, 1'b0);
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        model_reset();
        enable_clk   = 1'b0;
        sync_restart = 1'b0;
        cfg_valid    = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();

        // Free-running with reset config (H=3, L=2)
        run(12);

        // Enable gap while new_clk is high
        do_reset();
        run(3);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
        run(7);

        // H=1,L=1 captured at k=1; second offer in the same period refused
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1, 1);
        step(1'b1, 1'b0, 1'b1, 5, 5);
        run(3);
        run(8);

        // Zero config captured on a boundary edge waits a full period
        do_reset();
        for (int i = 0; i < 16 && m_k != m_h + m_l - 1; i++) run(1);
        step(1'b1, 1'b0, 1'b1, 0, 0);
        run(5);
        run(6);

        // Restart while high applies a pending config (H=2, L=4)
        do_reset();
        run(2);
        step(1'b1, 1'b0, 1'b1, 2, 4);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        run(12);

        // Mid-high reset with a pending config discards it
        do_reset();
        run(2);
        step(1'b1, 1'b0, 1'b1, 1, 1);
        do_reset();
        run(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
